// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: NREAD combinational read ports, two write lanes,
// write-to-read bypass and a per-register busy scoreboard.
module mips_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NREAD*ADDR_W-1:0] RAdr,
  output logic [NREAD*DATA_W-1:0] RData,
  output logic [NREAD-1:0]        RBusy,
  input  logic                    WE0,
  input  logic [ADDR_W-1:0]       WAdr0,
  input  logic [DATA_W-1:0]       WD0,
  input  logic                    WE1,
  input  logic [ADDR_W-1:0]       WAdr1,
  input  logic [DATA_W-1:0]       WD1,
  input  logic                    BSet,
  input  logic [ADDR_W-1:0]       BAdr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wen0;
  logic              wen1;
  logic              bset_en;

  // Writes (and busy sets) to r0 are dropped when r0 is hardwired.
  assign wen0    = WE0  && !((ZERO_REG != 0) && (WAdr0 == '0));
  assign wen1    = WE1  && !((ZERO_REG != 0) && (WAdr1 == '0));
  assign bset_en = BSet && !((ZERO_REG != 0) && (BAdr  == '0));

  // Set is applied after the clears so a new producer wins over a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (wen0)    busy_nxt[WAdr0] = 1'b0;
    if (wen1)    busy_nxt[WAdr1] = 1'b0;
    if (bset_en) busy_nxt[BAdr]  = 1'b1;
  end

  // Lane 1 is written last so it wins an address collision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wen0) regs[WAdr0] <= WD0;
      if (wen1) regs[WAdr1] <= WD1;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = RAdr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs[ra];
      rb = busy[ra];
      if (wen1 && (WAdr1 == ra)) begin
        rd = WD1;
        rb = 1'b0;
      end else if (wen0 && (WAdr0 == ra)) begin
        rd = WD0;
        rb = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      if (!Rst_n) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign RData[k*DATA_W +: DATA_W] = rd;
    assign RBusy[k]                  = rb;
  end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench: three register file configurations share one stimulus stream;
// a reference model predicts every read port and a negedge monitor checks them.
module tb_mips_regfile_mp;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  radr [4];
  logic        we0, we1, bset;
  logic [4:0]  wa0, wa1, badr;
  logic [31:0] wd0, wd1;

  logic [9:0]  a_radr;
  logic [11:0] c_radr;
  logic [63:0] a_rdata, b_rdata;
  logic [63:0] c_rdata;
  logic [1:0]  a_rbusy, b_rbusy;
  logic [3:0]  c_rbusy;

  always #5 Clk = ~Clk;

  assign a_radr = {radr[1], radr[0]};
  assign c_radr = {radr[3][2:0], radr[2][2:0], radr[1][2:0], radr[0][2:0]};

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .RAdr(a_radr), .RData(a_rdata), .RBusy(a_rbusy),
    .WE0(we0), .WAdr0(wa0), .WD0(wd0), .WE1(we1), .WAdr1(wa1), .WD1(wd1),
    .BSet(bset), .BAdr(badr));

  mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .RAdr(a_radr), .RData(b_rdata), .RBusy(b_rbusy),
    .WE0(we0), .WAdr0(wa0), .WD0(wd0), .WE1(we1), .WAdr1(wa1), .WD1(wd1),
    .BSet(bset), .BAdr(badr));

  mips_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(1)) u_c (
    .Clk(Clk), .Rst_n(Rst_n), .RAdr(c_radr), .RData(c_rdata[63:0]), .RBusy(c_rbusy),
    .WE0(we0), .WAdr0(wa0[2:0]), .WD0(wd0[15:0]), .WE1(we1), .WAdr1(wa1[2:0]),
    .WD1(wd1[15:0]), .BSet(bset), .BAdr(badr[2:0]));

  // Reference model: one register array and busy array per configuration.
  logic [31:0] mreg  [3][32];
  logic        mbusy [3][32];
  int unsigned zr    [3] = '{1, 0, 1};
  logic [4:0]  amask [3] = '{5'h1f, 5'h1f, 5'h07};
  logic [31:0] dmask [3] = '{32'hffff_ffff, 32'hffff_ffff, 32'h0000_ffff};

  typedef struct packed {
    logic [11:0][31:0] ed;
    logic [11:0]       eb;
  } exp_t;

  exp_t sb [$];
  int errors = 0;
  int checks = 0;

  function automatic bit lands(int d, logic en, logic [4:0] a);
    return en && !(zr[d] != 0 && (a & amask[d]) == 5'd0);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 32; r++) begin
        mreg[d][r]  = 32'd0;
        mbusy[d][r] = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      if (lands(d, we0, wa0)) begin
        mreg[d][wa0 & amask[d]]  = wd0 & dmask[d];
        mbusy[d][wa0 & amask[d]] = 1'b0;
      end
      if (lands(d, we1, wa1)) begin
        mreg[d][wa1 & amask[d]]  = wd1 & dmask[d];
        mbusy[d][wa1 & amask[d]] = 1'b0;
      end
      if (lands(d, bset, badr)) mbusy[d][badr & amask[d]] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Rst_n) model_edge();
    #1;
  endtask

  task automatic push();
    exp_t e;
    logic [4:0] a;
    e = '0;
    if (!Rst_n) model_clear();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++) begin
        a = radr[k] & amask[d];
        if (!Rst_n || (zr[d] != 0 && a == 5'd0)) begin
          e.ed[d*4+k] = 32'd0;
          e.eb[d*4+k] = 1'b0;
        end else if (lands(d, we1, wa1) && (wa1 & amask[d]) == a) begin
          e.ed[d*4+k] = wd1 & dmask[d];
          e.eb[d*4+k] = 1'b0;
        end else if (lands(d, we0, wa0) && (wa0 & amask[d]) == a) begin
          e.ed[d*4+k] = wd0 & dmask[d];
          e.eb[d*4+k] = 1'b0;
        end else begin
          e.ed[d*4+k] = mreg[d][a];
          e.eb[d*4+k] = mbusy[d][a];
        end
      end
    sb.push_back(e);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
  endtask

  task automatic set_rd(logic [4:0] r0, logic [4:0] r1, logic [4:0] r2, logic [4:0] r3);
    radr[0] = r0; radr[1] = r1; radr[2] = r2; radr[3] = r3;
  endtask

  // Monitor: every queued prediction is compared against all live read ports.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act_d;
      logic        act_b;
      int          np;
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
        np = (d == 2) ? 4 : 2;
        for (int k = 0; k < np; k++) begin
          case (d)
            0: begin act_d = a_rdata[k*32 +: 32]; act_b = a_rbusy[k]; end
            1: begin act_d = b_rdata[k*32 +: 32]; act_b = b_rbusy[k]; end
            default: begin act_d = {16'd0, c_rdata[k*16 +: 16]}; act_b = c_rbusy[k]; end
          endcase
          checks++;
          if (act_d !== e.ed[d*4+k]) begin
            errors++;
            $display("FAIL rdata dut%0d port%0d: got %h expected %h at %0t",
                     d, k, act_d, e.ed[d*4+k], $time);
          end
          checks++;
          if (act_b !== e.eb[d*4+k]) begin
            errors++;
            $display("FAIL rbusy dut%0d port%0d: got %b expected %b at %0t",
                     d, k, act_b, e.eb[d*4+k], $time);
          end
        end
      end
    end
  end

  initial begin
    Rst_n = 1'b0;
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; badr = '0;
    set_rd(5'd0, 5'd1, 5'd2, 5'd3);
    model_clear();
    tick(); push();
    tick(); Rst_n = 1'b1; push();

    // Asynchronous reset mid-cycle after a write to r5.
    tick(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; bset = 1'b1; badr = 5'd6;
    set_rd(5'd5, 5'd6, 5'd5, 5'd6); push();
    tick(); idle(); push();
    tick(); #2 Rst_n = 1'b0; push();
    tick(); Rst_n = 1'b1; push();

    // r3 write on lane 0, r0 write on lane 1.
    tick(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; set_rd(5'd3, 5'd0, 5'd3, 5'd0); push();
    tick(); idle(); push();

    // Dual-write collision on r7.
    tick(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h5555_FFFF; set_rd(5'd7, 5'd7, 5'd7, 5'd7); push();
    tick(); idle(); push();

    // Bypass on r9 with the old value still stored.
    tick(); we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0042; set_rd(5'd9, 5'd1, 5'd1, 5'd1); push();
    tick(); idle(); push();

    // Scoreboard: set, clear by lane 1, then set together with a lane-0 write.
    tick(); bset = 1'b1; badr = 5'd4; set_rd(5'd4, 5'd3, 5'd4, 5'd3); push();
    tick(); idle(); push();
    tick(); we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0BAD_F00D; push();
    tick(); idle(); push();
    tick(); bset = 1'b1; badr = 5'd4; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'hC0DE_0004; push();
    tick(); idle(); push();
    tick(); bset = 1'b1; badr = 5'd0; push();
    tick(); idle(); set_rd(5'd0, 5'd4, 5'd0, 5'd4); push();

    // Fill all eight low registers, then read them back four ports at a time.
    for (int i = 0; i < 8; i += 2) begin
      tick();
      we0 = 1'b1; wa0 = 5'(i);     wd0 = 32'h1000_0101 * (i + 1);
      we1 = 1'b1; wa1 = 5'(i + 1); wd1 = 32'h2000_0303 * (i + 2);
      set_rd(5'(i), 5'(i + 1), 5'(i ^ 1), 5'(i + 1)); push();
    end
    tick(); idle(); set_rd(5'd0, 5'd1, 5'd2, 5'd3); push();
    tick(); set_rd(5'd4, 5'd5, 5'd6, 5'd7); push();

    // Randomised traffic, biased to few addresses so collisions are common.
    for (int n = 0; n < 400; n++) begin
      tick();
      Rst_n = ($urandom_range(0, 63) != 0);
      we0  = $urandom_range(0, 1);
      we1  = $urandom_range(0, 2) == 0;
      bset = $urandom_range(0, 2) == 0;
      wa0  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa1  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      badr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd0  = $urandom;
      wd1  = $urandom;
      for (int k = 0; k < 4; k++)
        radr[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      push();
    end
    tick(); Rst_n = 1'b1; idle(); push();

    @(negedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
